// File: rtl/timer_555.sv
// timer_555: runtime-programmable 555 timer (astable / monostable) with cycle-complete strobe.
// Define TIMER_555_CV_EN to add the signed cv period offset with saturation.
module timer_555 #(
    parameter int WIDTH    = 16,
    parameter int CV_WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             mode,
    input  logic             trigger,
    input  logic [WIDTH-1:0] high_period,
    input  logic [WIDTH-1:0] low_period,
`ifdef TIMER_555_CV_EN
    input  logic [CV_WIDTH-1:0] cv,
`endif
    output logic             out,
    output logic             cycle_done
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             done_q, done_d;

    // Counter reload value Peff-1, with Peff saturated to [1, 2^WIDTH-1].
    function automatic logic [WIDTH-1:0] load_val(input logic [WIDTH-1:0] p);
`ifdef TIMER_555_CV_EN
        logic [WIDTH+1:0] s;
        s = {2'b00, p} + {{(WIDTH+2-CV_WIDTH){cv[CV_WIDTH-1]}}, cv};
        load_val = (s[WIDTH+1] || s == '0) ? '0 :
                   s[WIDTH] ? {{(WIDTH-1){1'b1}}, 1'b0} : s[WIDTH-1:0] - WIDTH'(1);
`else
        load_val = (p == '0) ? '0 : p - WIDTH'(1);
`endif
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (enable && (!mode || trigger)) begin
                state_d = HIGH;
                cnt_d   = load_val(high_period);
            end
            HIGH: if (cnt_q != '0) begin
                cnt_d = cnt_q - WIDTH'(1);
            end else if (mode) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = LOW;
                cnt_d   = load_val(low_period);
            end
            LOW: if (cnt_q != '0) begin
                cnt_d = cnt_q - WIDTH'(1);
            end else if (mode) begin
                state_d = IDLE;
            end else begin
                state_d = HIGH;
                cnt_d   = load_val(high_period);
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // Disabling parks in IDLE but keeps the count; the next phase entry reloads it.
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = cnt_q;
            done_d  = 1'b0;
        end
        out_d = (state_d == HIGH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign out        = out_q;
    assign cycle_done = done_q;
endmodule

// File: doc/timer_555.md
# timer_555

Parametrised, runtime-programmable 555 timer model that supersedes the fixed-period astable generator in the sound and timing paths. It is a single block with a selectable astable (free-running) or monostable (one-shot) mode. HIGH and LOW phase lengths are loaded at run time, and a cycle-complete strobe is provided. It sits between the CPU-written sound latches and the discrete-sound oscillators, one instance per tone or envelope source.

## Interface
Parameters:
- `WIDTH`, 16: width of the phase-length inputs and internal counter.
- `CV_WIDTH`, 8: width of the signed control-voltage offset. Used only with `TIMER_555_CV_EN`.

Ports:
- `clk`, in, 1: the single clock for all logic.
- `reset`, in, 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `enable`, in, 1: run permission; 0 forces IDLE.
- `mode`, in, 1: 0 = astable, 1 = monostable.
- `trigger`, in, 1: monostable start; level-sampled in IDLE only.
- `high_period`, in, WIDTH: HIGH phase length in clk cycles.
- `low_period`, in, WIDTH: LOW phase length in clk cycles.
- `cv`, in, CV_WIDTH: signed two's-complement period offset. The port is present only with `TIMER_555_CV_EN`.
- `out`, out, 1: timer output, registered.
- `cycle_done`, out, 1: one-cycle strobe on the final cycle of a completed period.

## Operation
The block has three states: IDLE (`out` = 0), HIGH (`out` = 1) and LOW (`out` = 0).

The effective period is computed as follows:
- `Peff` = the selected period, or that period + sign-extended `cv` when CV is enabled.
- The sum is computed at WIDTH+2 bits.
- The result is saturated to the range [1, 2^WIDTH−1]. A programmed 0 therefore behaves as 1.

A down-counter is loaded with `Peff`−1 on every phase entry. The period inputs are sampled only at that moment; changes mid-phase take effect at the next phase entry.

State transitions (each takes effect on the next edge):
- **IDLE → HIGH:**
  - when `enable`=1 and `mode`=0, or
  - when `enable`=1, `mode`=1 and `trigger`=1.
- **HIGH**, counter = 0:
  - if `mode`=0, go to LOW;
  - if `mode`=1, go to IDLE and assert `cycle_done`.
- **LOW**, counter = 0:
  - if `mode`=0, go to HIGH and assert `cycle_done`;
  - if `mode`=1, go to IDLE.

Other rules:
- `mode` is read only at phase boundaries. A change mid-phase never truncates the current phase.
- `trigger` during HIGH or LOW is ignored (no retrigger). If `trigger` is held high, the monostable refires after exactly one IDLE cycle.
- `enable`=0 in any state gives IDLE, `out`=0 and `cycle_done`=0 on the next edge. The counter is not cleared, but it is reloaded on the next phase entry.
- `reset` has priority over `enable`, `mode` and `trigger`. It is effective mid-phase with the same next-edge result as `enable`=0.

## Timing
- Reset values: state = IDLE, `out` = 0, `cycle_done` = 0, counter = 0.
- Latency from the IDLE start condition sampled at edge n: `out` = 1 after edge n, i.e. one cycle later.
- Astable, steady state: `out` is high for exactly `Peff(high)` cycles and low for exactly `Peff(low)` cycles. The period is H+L with no gap cycles.
- Monostable:
  - `out` is high for exactly `Peff(high)` cycles, then IDLE for at least 1 cycle.
  - Minimum trigger-to-trigger spacing is H+1 cycles.
- `cycle_done` is registered and coincident with the first cycle of the following state:
  - astable: the first HIGH cycle after a LOW;
  - monostable: the first IDLE cycle after a HIGH.
  
  It is exactly one cycle wide.
- Boundary: with H = L = 1 in astable, `out` toggles every cycle and `cycle_done` pulses every 2 cycles.

## Configuration
- `TIMER_555_CV_EN` defined:
  - the `cv` port exists;
  - `Peff` includes the signed offset with saturation as above;
  - this models modulation on the 555 CV pin for siren and warble effects.
- Not defined:
  - no `cv` port and no adder;
  - `Peff` = max(period, 1);
  - timing is otherwise identical.

## Test plan
- Astable, reset released, `enable`=1, H=3, L=5: `out` rises 1 cycle after the first enabled edge. The pattern is 3 high / 5 low, repeating, with `cycle_done` every 8 cycles.
- Monostable, H=4, single 1-cycle `trigger`: `out` is high for 4 cycles then returns to 0. `cycle_done` fires once. A second trigger at cycle 2 of HIGH is ignored.
- H=0, L=0, astable: behaves as H=L=1, so `out` alternates every cycle.
- Change `high_period` 3→7 mid-HIGH: the current HIGH still lasts 3 cycles and the next HIGH lasts 7. Change `mode` 0→1 mid-LOW: LOW completes, then the block goes to IDLE.
- Assert `reset` at cycle 2 of a 10-cycle HIGH: `out`=0 and `cycle_done`=0 on the next edge, and the block restarts cleanly afterwards. Repeat the same check with `enable`=0.
- With `TIMER_555_CV_EN`, WIDTH=8:
  - H=10, `cv`=−3 gives 7 high cycles;
  - H=2, `cv`=−100 gives 1 high cycle;
  - H=250, `cv`=+100 gives 255 high cycles.
